// File: rtl/result_demux.sv
// result_demux: return-path distributor for the VMU.
// Buffers result vectors in a 2-entry FIFO and offers the head entry to one
// of DEST_NUM destinations (one-hot out_valid, shared out_data). Beats whose
// destination index is out of range are dropped and counted.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   demux_en             enables input acceptance
//   in_valid/in_ready    input handshake; in_data is the vector, in_sel the destination
//   out_valid/out_ready  per-destination handshake; out_data is the head vector
//   drop_err             1-cycle pulse after an accepted beat with illegal in_sel
//   drop_cnt             saturating count of dropped beats
module result_demux #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned OP_NUM   = 8,
    parameter int unsigned DEST_NUM = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       demux_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W*OP_NUM-1:0]   in_data,
    input  logic [2:0]                 in_sel,
    output logic [DEST_NUM-1:0]        out_valid,
    input  logic [DEST_NUM-1:0]        out_ready,
    output logic [DATA_W*OP_NUM-1:0]   out_data,
    output logic                       drop_err,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned VEC_W = DATA_W * OP_NUM;
    localparam int unsigned SEL_W = 3;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              rd_ptr_n;
    logic [VEC_W-1:0]  mem_data [2];
    logic [SEL_W-1:0]  mem_sel  [2];

    logic              sel_legal;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic [SEL_W-1:0]  head_sel_n;
    logic [VEC_W-1:0]  head_data_n;
    logic [DEST_NUM-1:0] out_valid_n;
    logic [VEC_W-1:0]  out_data_n;

    // Acceptance depends only on registered occupancy, never on out_ready.
    assign in_ready = demux_en & (state != FULL);

    // Handshake decode and next occupancy state.
    always_comb begin
        sel_legal = (32'(in_sel) < DEST_NUM);
        accept    = in_valid & in_ready;
        push      = accept & sel_legal;
        drop      = accept & ~sel_legal;
        pop       = |(out_valid & out_ready);
        state_n   = state;
        case (state)
            EMPTY: if (push) state_n = ONE;
            ONE: begin
                if (push && !pop)      state_n = FULL;
                else if (!push && pop) state_n = EMPTY;
            end
            FULL:  if (pop) state_n = ONE;
            default: state_n = EMPTY;
        endcase
    end

    // Next head: the beat being written this cycle becomes head when the
    // read pointer lands on the slot it is written to (empty push, or
    // push+pop with one entry buffered).
    always_comb begin
        rd_ptr_n    = rd_ptr ^ pop;
        head_sel_n  = mem_sel[rd_ptr_n];
        head_data_n = mem_data[rd_ptr_n];
        if (push && (wr_ptr == rd_ptr_n)) begin
            head_sel_n  = in_sel;
            head_data_n = in_data;
        end
        out_valid_n = '0;
        out_data_n  = out_data;
        if (state_n != EMPTY) begin
            out_valid_n = DEST_NUM'(1) << head_sel_n;
            out_data_n  = head_data_n;
        end
    end

    // FIFO state, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr ^ push;
            rd_ptr    <= rd_ptr_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_sel[0]  <= '0;
            mem_sel[1]  <= '0;
        end else if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_sel[wr_ptr]  <= in_sel;
        end
    end

    // Drop reporting; counter saturates at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err <= 1'b0;
            drop_cnt <= '0;
        end else begin
            drop_err <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
